// File: rtl/ptmch_cmd_sched.sv
// rtl/ptmch_cmd_sched.sv - round-robin SPI-NAND command scheduler with address windows and completion counters
module ptmch_cmd_sched #(
  parameter int ADDR_W  = 24,
  parameter int CNT_W   = 32,
  parameter int TMO_CYC = 4096
) (
  input  logic                CLK100M,
  input  logic                RESET,
  input  logic [4:0]          REQ_VALID,
  input  logic [5*ADDR_W-1:0] REQ_ADDR,
  output logic [4:0]          REQ_ACK,
  output logic [4:0]          REQ_REJ,
  input  logic [5*ADDR_W-1:0] WIN_LOW,
  input  logic [5*ADDR_W-1:0] WIN_HIGH,
  output logic                CMD_VALID,
  output logic [2:0]          CMD_TYPE,
  output logic [ADDR_W-1:0]   CMD_ADDR,
  input  logic                CMD_READY,
  input  logic                CMD_DONE,
  input  logic                CNT_CLR,
  output logic [5*CNT_W-1:0]  CNT_OUT,
  output logic                BUSY,
  output logic                TMO_ERR
);
  localparam int               TMR_W     = $clog2(TMO_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TMO_CYC - 1);
  localparam logic [2:0]       TYPE_IDLE = 3'd7;

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_REJECT} state_t;

  state_t                state_q, state_d;
  logic [2:0]            rr_q, rr_d;
  logic [2:0]            idx_q, idx_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  cmd_valid_q, cmd_valid_d;
  logic [2:0]            cmd_type_q, cmd_type_d;
  logic [ADDR_W-1:0]     cmd_addr_q, cmd_addr_d;
  logic [4:0]            req_ack_q, req_ack_d;
  logic [4:0]            req_rej_q, req_rej_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic                  tmo_err_q, tmo_err_d;
  logic                  busy_q, busy_d;
  logic [4:0][CNT_W-1:0] cnt_q, cnt_d;

  logic [4:0][ADDR_W-1:0] req_addr_a, win_lo_a, win_hi_a;
  logic [2:0]             pick_idx;
  logic                   in_win;

  assign req_addr_a = REQ_ADDR;
  assign win_lo_a   = WIN_LOW;
  assign win_hi_a   = WIN_HIGH;

  // First valid requester strictly after the last served one, wrapping 4 -> 0.
  always_comb begin : pick_rr
    logic       found;
    logic [3:0] sum;
    logic [2:0] cand;
    found    = 1'b0;
    pick_idx = 3'd0;
    sum      = 4'd0;
    cand     = 3'd0;
    for (int k = 1; k <= 5; k++) begin
      sum  = {1'b0, rr_q} + 4'(k);
      cand = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
      if (!found && REQ_VALID[cand]) begin
        found    = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // An inverted window (low > high) can never be satisfied, so it rejects everything.
  assign in_win = (addr_q >= win_lo_a[idx_q]) && (addr_q <= win_hi_a[idx_q]);

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    cmd_valid_d = cmd_valid_q;
    cmd_type_d  = cmd_type_q;
    cmd_addr_d  = cmd_addr_q;
    req_ack_d   = 5'd0;
    req_rej_d   = 5'd0;
    timer_d     = timer_q;
    tmo_err_d   = tmo_err_q;
    cnt_d       = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (|REQ_VALID) begin
          idx_d   = pick_idx;
          addr_d  = req_addr_a[pick_idx];
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (in_win) begin
          cmd_valid_d = 1'b1;
          cmd_type_d  = idx_q;
          cmd_addr_d  = addr_q;
          state_d     = S_ISSUE;
        end else begin
          req_rej_d[idx_q] = 1'b1;
          state_d          = S_REJECT;
        end
      end
      S_REJECT: begin
        rr_d    = idx_q;
        state_d = S_IDLE;
      end
      S_ISSUE: begin
        if (CMD_READY) begin
          cmd_valid_d      = 1'b0;
          req_ack_d[idx_q] = 1'b1;
          rr_d             = idx_q;
          timer_d          = '0;
          state_d          = S_WAIT;
        end
      end
      S_WAIT: begin
        // Completion on the last allowed cycle still counts as done.
        if (CMD_DONE) begin
          if (cnt_q[idx_q] != '1) begin
            cnt_d[idx_q] = cnt_q[idx_q] + CNT_W'(1);
          end
          cmd_type_d = TYPE_IDLE;
          state_d    = S_IDLE;
        end else if (timer_q == TMR_LAST) begin
          tmo_err_d  = 1'b1;
          cmd_type_d = TYPE_IDLE;
          state_d    = S_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: begin
        cmd_valid_d = 1'b0;
        cmd_type_d  = TYPE_IDLE;
        state_d     = S_IDLE;
      end
    endcase

    if (CNT_CLR) begin
      cnt_d     = '0;
      tmo_err_d = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK100M) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      rr_q        <= 3'd4;
      idx_q       <= 3'd0;
      addr_q      <= '0;
      cmd_valid_q <= 1'b0;
      cmd_type_q  <= TYPE_IDLE;
      cmd_addr_q  <= '0;
      req_ack_q   <= 5'd0;
      req_rej_q   <= 5'd0;
      timer_q     <= '0;
      tmo_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_type_q  <= cmd_type_d;
      cmd_addr_q  <= cmd_addr_d;
      req_ack_q   <= req_ack_d;
      req_rej_q   <= req_rej_d;
      timer_q     <= timer_d;
      tmo_err_q   <= tmo_err_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
    end
  end

  assign REQ_ACK   = req_ack_q;
  assign REQ_REJ   = req_rej_q;
  assign CMD_VALID = cmd_valid_q;
  assign CMD_TYPE  = cmd_type_q;
  assign CMD_ADDR  = cmd_addr_q;
  assign CNT_OUT   = cnt_q;
  assign BUSY      = busy_q;
  assign TMO_ERR   = tmo_err_q;

endmodule
